sram_controller: RTL



---
 rtl/sram_controller.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// Data-memory stage controller: splits each 32-bit load/store into two
// 16-bit accesses on an asynchronous SRAM and stalls the pipeline meanwhile.
module sram_controller #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned PHASE_CYCLES  = 2,
    parameter int unsigned SRAM_ADDR_LEN = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic                     wr_en,
    input  logic [31:0]              address,
    input  logic [31:0]              write_data,
    output logic [31:0]              read_data,
    output logic                     ready,
    inout  wire  [15:0]              sram_dq,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    output logic                     sram_we_n,
    output logic                     sram_ce_n,
    output logic                     sram_oe_n,
    output logic                     sram_ub_n,
    output logic                     sram_lb_n
);

    localparam int unsigned CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] READ_LO  = 3'd1;
    localparam logic [2:0] READ_HI  = 3'd2;
    localparam logic [2:0] WRITE_LO = 3'd3;
    localparam logic [2:0] WRITE_HI = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]              offset;
    logic [SRAM_ADDR_LEN-1:0] lo_addr;
    logic [SRAM_ADDR_LEN-1:0] hi_addr;
    logic                     last;
    logic                     in_phase;
    logic                     wr_phase;
    logic                     hi_phase;
    logic                     unused_offset;

    // Halfword address = word address * 2, wrapping at the SRAM size
    assign offset        = address - BASE_ADDR;
    assign lo_addr       = {offset[SRAM_ADDR_LEN:2], 1'b0};
    assign hi_addr       = {offset[SRAM_ADDR_LEN:2], 1'b1};
    assign unused_offset = ^{offset[31:SRAM_ADDR_LEN+1], offset[1:0]};

    assign last     = (cnt_q == LAST);
    assign wr_phase = (state_q == WRITE_LO) || (state_q == WRITE_HI);
    assign hi_phase = (state_q == READ_HI) || (state_q == WRITE_HI);
    assign in_phase = wr_phase || (state_q == READ_LO) || (state_q == READ_HI);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (wr_en) begin
                    state_d = WRITE_LO;
                end else if (rd_en) begin
                    state_d = READ_LO;
                end
            end
            READ_LO:  if (last) state_d = READ_HI;
            READ_HI:  if (last) state_d = DONE;
            WRITE_LO: if (last) state_d = WRITE_HI;
            WRITE_HI: if (last) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (in_phase && (state_d == state_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if ((state_q == READ_LO) && last) begin
            rdata_d[15:0] = sram_dq;
        end
        if ((state_q == READ_HI) && last) begin
            rdata_d[31:16] = sram_dq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign read_data = rdata_q;
    assign ready     = (state_q == DONE) ||
                       ((state_q == IDLE) && !rd_en && !wr_en);

    assign sram_addr = hi_phase ? hi_addr : lo_addr;
    assign sram_we_n = !wr_phase;
    assign sram_dq   = wr_phase ? (hi_phase ? write_data[31:16]
                                            : write_data[15:0])
                                : 16'hzzzz;

    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

endmodule
